// File: rtl/mem_block_responder_pkg.sv
// Shared cache geometry for the memory-side blocks of the cache system.
// The widths here are the common defaults every block of the cache agrees on;
// each block keeps its own state encoding privately.
package mem_block_responder_pkg;

    // log2 of the number of words in one cache block
    localparam int CACHE_BW_BLOCK = 2;

    // width of a word address into backing memory
    localparam int CACHE_BW_WORD_ADDR = 10;

    // width of one memory word
    localparam int WORD_W = 32;

endpackage

// File: rtl/mem_block_responder.sv
// Memory-side responder for the cache. It accepts one command at a time. A read
// command fetches a word or a whole block from the backing RAM and pushes it into
// the return buffer. A write command pops words from the writeback buffer and
// stores them in the RAM. Every output is a register. A command is fully finished
// before the next one is accepted, so returned data never interleaves with a
// writeback.
module mem_block_responder
    import mem_block_responder_pkg::*;
#(
    parameter int BW_BLOCK     = CACHE_BW_BLOCK,
    parameter int BW_WORD_ADDR = CACHE_BW_WORD_ADDR
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    req_i,
    input  logic                    req_block_i,
    input  logic                    rw_i,
    input  logic [BW_WORD_ADDR-1:0] addr_i,
    output logic                    ready_o,
    input  logic                    buffer_write_ready_i,
    output logic [WORD_W-1:0]       buffer_data_o,
    output logic                    buffer_write_ack_o,
    input  logic                    buffer_read_ready_i,
    input  logic [WORD_W-1:0]       buffer_data_i,
    output logic                    buffer_read_ack_o,
    output logic [BW_WORD_ADDR-1:0] ram_addr_o,
    output logic                    ram_wren_o,
    output logic [WORD_W-1:0]       ram_data_o,
    input  logic [WORD_W-1:0]       ram_data_i,
    output logic                    done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_PUSH,
        ST_WR_POP
    } state_t;

    localparam logic [BW_BLOCK:0]       CNT_ONE     = (BW_BLOCK+1)'(1);
    localparam logic [BW_BLOCK:0]       BLOCK_WORDS = CNT_ONE << BW_BLOCK;
    localparam logic [BW_WORD_ADDR-1:0] BLOCK_MASK  =
        ~((BW_WORD_ADDR'(1) << BW_BLOCK) - BW_WORD_ADDR'(1));

    state_t                  state, state_next;
    logic [BW_WORD_ADDR-1:0] base_q, base_next;
    logic [BW_BLOCK:0]       count_q, count_next;
    logic [BW_BLOCK:0]       words_q, words_next;

    logic                    ready_next;
    logic [WORD_W-1:0]       buffer_data_next;
    logic                    buffer_write_ack_next;
    logic                    buffer_read_ack_next;
    logic [BW_WORD_ADDR-1:0] ram_addr_next;
    logic                    ram_wren_next;
    logic [WORD_W-1:0]       ram_data_next;
    logic                    done_next;

    logic [BW_BLOCK:0]       count_inc;
    logic                    last_word;
    logic                    accept;
    logic [BW_WORD_ADDR-1:0] start_base;

    // A request is only honoured while ready_o is visibly high; block commands align to their block
    assign count_inc  = count_q + CNT_ONE;
    assign last_word  = (count_inc == words_q);
    assign accept     = ready_o && req_i;
    assign start_base = req_block_i ? (addr_i & BLOCK_MASK) : addr_i;

    // Next-state and next-output logic; data outputs hold their last value unless a transfer updates them
    always_comb begin
        state_next            = state;
        base_next             = base_q;
        count_next            = count_q;
        words_next            = words_q;
        ready_next            = 1'b0;
        buffer_data_next      = buffer_data_o;
        buffer_write_ack_next = 1'b0;
        buffer_read_ack_next  = 1'b0;
        ram_addr_next         = ram_addr_o;
        ram_wren_next         = 1'b0;
        ram_data_next         = ram_data_o;
        done_next             = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    base_next  = start_base;
                    words_next = req_block_i ? BLOCK_WORDS : CNT_ONE;
                    count_next = '0;
                    if (rw_i) begin
                        state_next = ST_WR_POP;
                    end else begin
                        state_next    = ST_RD_ISSUE;
                        ram_addr_next = start_base;
                    end
                end else begin
                    ready_next = 1'b1;
                end
            end

            ST_RD_ISSUE: begin
                state_next = ST_RD_PUSH;
            end

            ST_RD_PUSH: begin
                if (buffer_write_ready_i) begin
                    buffer_data_next      = ram_data_i;
                    buffer_write_ack_next = 1'b1;
                    count_next            = count_inc;
                    if (last_word) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next    = ST_RD_ISSUE;
                        ram_addr_next = base_q + BW_WORD_ADDR'(count_inc);
                    end
                end
            end

            ST_WR_POP: begin
                if (buffer_read_ready_i) begin
                    buffer_read_ack_next = 1'b1;
                    ram_addr_next        = base_q + BW_WORD_ADDR'(count_q);
                    ram_data_next        = buffer_data_i;
                    ram_wren_next        = 1'b1;
                    count_next           = count_inc;
                    if (last_word) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, transfer bookkeeping and every output register; reset abandons any transfer in flight
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state              <= ST_IDLE;
            base_q             <= '0;
            count_q            <= '0;
            words_q            <= '0;
            ready_o            <= 1'b0;
            buffer_data_o      <= '0;
            buffer_write_ack_o <= 1'b0;
            buffer_read_ack_o  <= 1'b0;
            ram_addr_o         <= '0;
            ram_wren_o         <= 1'b0;
            ram_data_o         <= '0;
            done_o             <= 1'b0;
        end else begin
            state              <= state_next;
            base_q             <= base_next;
            count_q            <= count_next;
            words_q            <= words_next;
            ready_o            <= ready_next;
            buffer_data_o      <= buffer_data_next;
            buffer_write_ack_o <= buffer_write_ack_next;
            buffer_read_ack_o  <= buffer_read_ack_next;
            ram_addr_o         <= ram_addr_next;
            ram_wren_o         <= ram_wren_next;
            ram_data_o         <= ram_data_next;
            done_o             <= done_next;
        end
    end

endmodule

// File: doc/mem_block_responder.md
MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

Interface
REQ-001 SHALL take parameter BW_BLOCK, default `BW_BLOCK; log2 of words per block.
REQ-002 SHALL take parameter BW_WORD_ADDR, default `BW_WORD_ADDR; word-address width.
REQ-003 SHALL use one clock and a synchronous, active-high reset; ports: clock_i in 1, rising-edge clock; reset_i in 1, synchronous active-high reset.
REQ-004 SHALL have the following command ports:
- req_i in 1: command strobe.
- req_block_i in 1: 1 = block transfer, 0 = single word.
- rw_i in 1: 0 = read from memory, 1 = write to memory.
- addr_i in BW_WORD_ADDR: word address.
- ready_o out 1: idle, command accepted this cycle.
REQ-005 SHALL have the following return-buffer ports (memory -> cache direction):
- buffer_write_ready_i in 1: buffer has space.
- buffer_data_o out 32: word pushed.
- buffer_write_ack_o out 1: push strobe.
REQ-006 SHALL have the following writeback-buffer ports (cache -> memory direction):
- buffer_read_ready_i in 1: word available.
- buffer_data_i in 32: head word.
- buffer_read_ack_o out 1: pop strobe.
REQ-007 SHALL have the following backing-RAM ports:
- ram_addr_o out BW_WORD_ADDR.
- ram_wren_o out 1.
- ram_data_o out 32.
- ram_data_i in 32: valid exactly one cycle after ram_addr_o is presented.
REQ-008 SHALL drive done_o out 1: one-cycle pulse when a command completes.

Function
REQ-009 SHALL register every output.
REQ-010 SHALL implement four states:
- ST_IDLE
- ST_RD_ISSUE
- ST_RD_PUSH
- ST_WR_POP
REQ-011 SHALL assert ready_o only in ST_IDLE, and SHALL sample req_i only when ready_o=1; req_i while ready_o=0 is ignored, not queued.
REQ-012 SHALL, on an accepted command, latch:
- base address = addr_i, with the low BW_BLOCK bits cleared for block commands and unchanged for word commands;
- word count = 2^BW_BLOCK for block commands, 1 for word commands;
- transfer counter (BW_BLOCK+1 bits) = 0.
REQ-013 SHALL, on an accepted command, deassert ready_o the following cycle and go to ST_RD_ISSUE (rw_i=0) or ST_WR_POP (rw_i=1).
REQ-014 SHALL, in ST_RD_ISSUE, drive ram_addr_o = base + counter with ram_wren_o=0, then go to ST_RD_PUSH next cycle.
REQ-015 SHALL, in ST_RD_PUSH, wait while buffer_write_ready_i=0 while holding ram_addr_o; when buffer_write_ready_i=1:
- drive buffer_data_o = ram_data_i and pulse buffer_write_ack_o for one cycle;
- increment the counter;
- go to ST_RD_ISSUE if words remain, else to ST_IDLE.
Read throughput is therefore one word per two cycles when not stalled.
REQ-016 SHALL, in ST_WR_POP, wait while buffer_read_ready_i=0; when buffer_read_ready_i=1:
- pulse buffer_read_ack_o;
- drive ram_addr_o = base + counter, ram_data_o = buffer_data_i, ram_wren_o=1 for one cycle;
- increment the counter;
- go to ST_IDLE after the last word.
Write throughput is one word per cycle.
REQ-017 SHALL compute address arithmetic modulo 2^BW_WORD_ADDR; a word command at the maximum address SHALL NOT wrap into a neighbouring block.
REQ-018 SHALL pulse done_o in the cycle the final push or pop strobe is issued, and SHALL return ready_o=1 the cycle after.
REQ-019 SHALL complete each command before accepting the next, so a read issued before a writeback is fully returned before any writeback word is popped; the system's return buffer therefore holds at least 2^BW_BLOCK words.
REQ-020 SHALL never assert buffer_write_ack_o and buffer_read_ack_o in the same cycle, and SHALL never pulse either strobe while its ready input is 0.

Reset
REQ-021 SHALL return to ST_IDLE when reset_i=1 at a clock edge, from any state including mid-block; the partial transfer is abandoned and no further strobes are issued.
REQ-022 SHALL, during reset, hold ready_o, buffer_write_ack_o, buffer_read_ack_o, ram_wren_o and done_o at 0, hold buffer_data_o, ram_data_o and ram_addr_o at 0, and clear the counter; ready_o SHALL rise on the first edge after reset_i falls.

Structure
REQ-023 SHALL take BW_BLOCK and BW_WORD_ADDR from the shared cache.h header; state encodings stay local.
REQ-024 SHALL have no sub-module; the bench SHALL supply a behavioural one-cycle-latency RAM model named mem_block_ram.

Verification (BW_BLOCK=2, RAM[i]=i+0x1000)
REQ-025 Block read at addr 0x13 -> base 0x10; pushes 0x1010..0x1013 in order; exactly 4 acks; done_o on the 4th ack.
REQ-026 Block write at 0x20 with buffer holding A0..A3 -> RAM[0x20..0x23]=A0..A3; 4 pops on consecutive cycles; done_o with the last pop.
REQ-027 Block read with buffer_write_ready_i held low for 5 cycles before the 2nd word -> no duplicated or dropped word; ram_addr_o held at 0x11 while stalled.
REQ-028 Read at 0x40 then writeback to 0x80 requested while busy -> the second request is ignored until ready_o=1; re-issued, it completes after all 4 read pushes.
REQ-029 reset_i asserted after the 2nd pop of a block write -> all strobes 0 the next cycle; RAM[0x22..0x23] unchanged; ready_o=1 one cycle after reset is released.
REQ-030 Word read at 0x3FF (req_block_i=0) -> exactly one push of RAM[0x3FF], then done_o.
